// File: rtl/usb_rx_seq_pkg.sv
// usb_rx_seq_pkg
// Shared encodings for the receive-side transaction sequencer:
//   rx_pkt_e  - status codes reported by usb_rx
//   tx_pkt_e  - response codes requested from usb_tx
//   state_e   - sequencer FSM states
package usb_rx_seq_pkg;

    typedef enum logic [2:0] {
        RX_NONE  = 3'b000,
        RX_IN    = 3'b001,
        RX_OUT   = 3'b010,
        RX_ACK   = 3'b011,
        RX_ERROR = 3'b100,
        RX_DONE  = 3'b101,
        RX_DATA  = 3'b110
    } rx_pkt_e;

    typedef enum logic [2:0] {
        TX_NONE  = 3'b000,
        TX_DATA0 = 3'b001,
        TX_ACK   = 3'b010,
        TX_NAK   = 3'b011
    } tx_pkt_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOK_OUT,
        S_TOK_IN,
        S_WAIT_DATA,
        S_RX_DATA,
        S_RESP
    } state_e;

endpackage

// File: rtl/usb_rx_crc_strip.sv
// usb_rx_crc_strip
// Two-byte hold pipeline. Every received byte is delayed by two strobes, so
// when the packet ends the last two bytes (the CRC16) are still in the hold
// stage and are simply discarded by the next clear.
// Ports:
//   clk, n_rst  - clock, synchronous active-low reset
//   shift       - accept data (one received byte)
//   clear       - empty the hold stage (wins over shift)
//   data        - incoming byte
//   emit_valid  - combinational: oldest byte leaves this cycle
//   emit_data   - the byte leaving
//   fill        - bytes currently held (0..2)
module usb_rx_crc_strip (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       shift,
    input  logic       clear,
    input  logic [7:0] data,
    output logic       emit_valid,
    output logic [7:0] emit_data,
    output logic [1:0] fill
);

    logic [7:0] old_q, old_d;
    logic [7:0] new_q, new_d;
    logic [1:0] fill_q, fill_d;

    always_comb begin
        old_d      = old_q;
        new_d      = new_q;
        fill_d     = fill_q;
        emit_valid = 1'b0;
        emit_data  = old_q;
        if (clear) begin
            old_d  = 8'h00;
            new_d  = 8'h00;
            fill_d = 2'd0;
        end else if (shift) begin
            emit_valid = (fill_q == 2'd2);
            old_d      = new_q;
            new_d      = data;
            if (fill_q != 2'd2) begin
                fill_d = fill_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            old_q  <= 8'h00;
            new_q  <= 8'h00;
            fill_q <= 2'd0;
        end else begin
            old_q  <= old_d;
            new_q  <= new_d;
            fill_q <= fill_d;
        end
    end

    assign fill = fill_q;

endmodule

// File: rtl/usb_rx_sequencer.sv
// usb_rx_sequencer
// Transaction-level controller behind usb_rx: follows token / data / DONE,
// pushes the data payload (CRC16 stripped) into the endpoint FIFO and asks
// usb_tx for the handshake or data response.
// Ports:
//   clk, n_rst            - clock, synchronous active-low reset
//   rx_packet             - usb_rx status code (rx_pkt_e)
//   rx_packet_data        - received byte, valid with store_rx_packet_data
//   store_rx_packet_data  - byte strobe
//   buffer_occupancy      - endpoint FIFO fill in bytes
//   tx_done               - tx side finished the requested packet
//   rx_push/rx_push_data  - FIFO write strobe and byte
//   tx_packet/tx_start    - requested response (tx_pkt_e) and launch pulse
//   rx_data_ready         - OUT transaction accepted
//   rx_byte_count         - payload bytes pushed in current/last data packet
//   rx_error              - transaction aborted
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for an IN or OUT token
// S_TOK_OUT   | OUT token body arriving, waiting for its DONE
// S_TOK_IN    | IN token body arriving, waiting for its DONE
// S_WAIT_DATA | OUT token complete, waiting (timed) for the data packet
// S_RX_DATA   | data packet arriving, payload pushed through hold stage
// S_RESP      | response requested, holding tx_packet until tx_done
module usb_rx_sequencer
    import usb_rx_seq_pkg::*;
#(
    parameter int BUF_DEPTH      = 64,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] rx_packet,
    input  logic [7:0] rx_packet_data,
    input  logic       store_rx_packet_data,
    input  logic [6:0] buffer_occupancy,
    input  logic       tx_done,
    output logic       rx_push,
    output logic [7:0] rx_push_data,
    output logic [2:0] tx_packet,
    output logic       tx_start,
    output logic       rx_data_ready,
    output logic [6:0] rx_byte_count,
    output logic       rx_error
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [6:0]       DEPTH_W   = 7'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_W = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             ovf_q, ovf_d;
    logic [6:0]       byte_cnt_q, byte_cnt_d;
    logic             rx_push_q, rx_push_d;
    logic [7:0]       push_data_q, push_data_d;
    logic [2:0]       tx_packet_q, tx_packet_d;
    logic             tx_start_q, tx_start_d;
    logic             ready_q, ready_d;
    logic             error_q, error_d;

    logic       ev_in, ev_out, ev_done, ev_data, ev_error;
    logic       hold_shift, hold_clear, emit_valid;
    logic [7:0] emit_data;
    logic [1:0] hold_fill, fill_after;
    logic       has_room, push_w, ovf_now;

    // Only a change of rx_packet is an event; a held status is never re-acted on.
    always_comb begin
        prev_d   = rx_packet;
        ev_in    = (rx_packet != prev_q) && (rx_packet == RX_IN);
        ev_out   = (rx_packet != prev_q) && (rx_packet == RX_OUT);
        ev_done  = (rx_packet != prev_q) && (rx_packet == RX_DONE);
        ev_data  = (rx_packet != prev_q) && (rx_packet == RX_DATA);
        ev_error = (rx_packet != prev_q) && (rx_packet == RX_ERROR);
        // A byte racing an ERROR is abandoned with the rest of the packet.
        hold_shift = store_rx_packet_data && (state_q == S_RX_DATA) && !ev_error;
        hold_clear = (state_q != S_RX_DATA);
    end

    usb_rx_crc_strip u_crc_strip (
        .clk        (clk),
        .n_rst      (n_rst),
        .shift      (hold_shift),
        .clear      (hold_clear),
        .data       (rx_packet_data),
        .emit_valid (emit_valid),
        .emit_data  (emit_data),
        .fill       (hold_fill)
    );

    // A strobe coinciding with DONE is folded in before DONE is judged, so
    // the decision uses the post-strobe fill and overflow.
    always_comb begin
        has_room   = (buffer_occupancy < DEPTH_W);
        push_w     = emit_valid && has_room;
        ovf_now    = ovf_q || (emit_valid && !has_room);
        fill_after = (hold_shift && (hold_fill != 2'd2)) ? hold_fill + 2'd1 : hold_fill;
        cnt_inc    = cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_now;
        byte_cnt_d  = byte_cnt_q;
        rx_push_d   = push_w;
        push_data_d = push_w ? emit_data : push_data_q;
        tx_packet_d = tx_packet_q;
        tx_start_d  = 1'b0;
        ready_d     = 1'b0;
        error_d     = 1'b0;

        if (push_w && (byte_cnt_q != 7'd127)) begin
            byte_cnt_d = byte_cnt_q + 7'd1;
        end

        if (ev_error && (state_q != S_RESP)) begin
            state_d = S_IDLE;
            error_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ev_out) begin
                        state_d = S_TOK_OUT;
                    end else if (ev_in) begin
                        state_d = S_TOK_IN;
                    end
                end
                S_TOK_OUT: begin
                    if (ev_done) begin
                        state_d = S_WAIT_DATA;
                        cnt_d   = '0;
                    end
                end
                S_TOK_IN: begin
                    if (ev_done) begin
                        state_d     = S_RESP;
                        tx_start_d  = 1'b1;
                        tx_packet_d = (buffer_occupancy != 7'd0) ? TX_DATA0 : TX_NAK;
                    end
                end
                S_WAIT_DATA: begin
                    cnt_d = cnt_inc;
                    if (ev_data) begin
                        state_d    = S_RX_DATA;
                        ovf_d      = 1'b0;
                        byte_cnt_d = 7'd0;
                    end else if (ev_done || (cnt_inc == TIMEOUT_W)) begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                    end
                end
                S_RX_DATA: begin
                    if (ev_done) begin
                        if (fill_after != 2'd2) begin
                            state_d = S_IDLE;
                            error_d = 1'b1;
                        end else begin
                            state_d    = S_RESP;
                            tx_start_d = 1'b1;
                            if (ovf_now) begin
                                tx_packet_d = TX_NAK;
                            end else begin
                                tx_packet_d = TX_ACK;
                                ready_d     = 1'b1;
                            end
                        end
                    end
                end
                S_RESP: begin
                    if (tx_done) begin
                        state_d     = S_IDLE;
                        tx_packet_d = TX_NONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            prev_q      <= 3'b000;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            byte_cnt_q  <= 7'd0;
            rx_push_q   <= 1'b0;
            push_data_q <= 8'h00;
            tx_packet_q <= 3'b000;
            tx_start_q  <= 1'b0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_push_q   <= rx_push_d;
            push_data_q <= push_data_d;
            tx_packet_q <= tx_packet_d;
            tx_start_q  <= tx_start_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
        end
    end

    assign rx_push       = rx_push_q;
    assign rx_push_data  = push_data_q;
    assign tx_packet     = tx_packet_q;
    assign tx_start      = tx_start_q;
    assign rx_data_ready = ready_q;
    assign rx_byte_count = byte_cnt_q;
    assign rx_error      = error_q;

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Bench for usb_rx_sequencer. OUT transactions are checked against a
// transaction-level model: the FIFO level starts at o0 and grows by one per
// accepted byte; the byte leaving at strobe k is payload byte k-2 and is
// accepted only while the level is below the buffer depth.
module tb_usb_rx_sequencer;

    localparam logic [2:0] P_IN    = 3'b001;
    localparam logic [2:0] P_OUT   = 3'b010;
    localparam logic [2:0] P_ERROR = 3'b100;
    localparam logic [2:0] P_DONE  = 3'b101;
    localparam logic [2:0] P_DATA  = 3'b110;
    localparam logic [2:0] T_NONE  = 3'b000;
    localparam logic [2:0] T_DATA0 = 3'b001;
    localparam logic [2:0] T_ACK   = 3'b010;
    localparam logic [2:0] T_NAK   = 3'b011;
    localparam int         DEPTH   = 64;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [2:0] rx_packet;
    logic [7:0] rx_packet_data;
    logic       store_rx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       tx_done;
    logic       rx_push;
    logic [7:0] rx_push_data;
    logic [2:0] tx_packet;
    logic       tx_start;
    logic       rx_data_ready;
    logic [6:0] rx_byte_count;
    logic       rx_error;

    int checks   = 0;
    int failures = 0;
    int n_push   = 0;
    int n_start  = 0;
    int n_err    = 0;

    logic [7:0] pay [16];
    int         pay_n;

    usb_rx_sequencer #(.BUF_DEPTH(64), .TIMEOUT_CYCLES(2048)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .rx_packet            (rx_packet),
        .rx_packet_data       (rx_packet_data),
        .store_rx_packet_data (store_rx_packet_data),
        .buffer_occupancy     (buffer_occupancy),
        .tx_done              (tx_done),
        .rx_push              (rx_push),
        .rx_push_data         (rx_push_data),
        .tx_packet            (tx_packet),
        .tx_start             (tx_start),
        .rx_data_ready        (rx_data_ready),
        .rx_byte_count        (rx_byte_count),
        .rx_error             (rx_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_push)  n_push  <= n_push + 1;
        if (tx_start) n_start <= n_start + 1;
        if (rx_error) n_err   <= n_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pkt(input logic [2:0] v);
        rx_packet = v;
        tick(1);
    endtask

    task automatic byte_strobe(input logic [7:0] b);
        rx_packet_data       = b;
        store_rx_packet_data = 1'b1;
        tick(1);
        store_rx_packet_data = 1'b0;
        tick(63);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_push"},   32'(rx_push), 0);
        check({tag, "_pdata"},  32'(rx_push_data), 0);
        check({tag, "_txpkt"},  32'(tx_packet), 0);
        check({tag, "_start"},  32'(tx_start), 0);
        check({tag, "_ready"},  32'(rx_data_ready), 0);
        check({tag, "_bcnt"},   32'(rx_byte_count), 0);
        check({tag, "_err"},    32'(rx_error), 0);
    endtask

    task automatic tx_finish(input logic [2:0] exp_pkt);
        tick(3);
        check("pkt_held", 32'(tx_packet), 32'(exp_pkt));
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        tick(1);
        check("pkt_clear", 32'(tx_packet), 32'(T_NONE));
    endtask

    task automatic in_txn(input int o);
        logic [2:0] exp_pkt;
        int base_start;
        base_start = n_start;
        exp_pkt = (o != 0) ? T_DATA0 : T_NAK;
        pkt(P_IN);
        byte_strobe(8'h81);
        byte_strobe(8'h58);
        buffer_occupancy = 7'(o);
        pkt(P_DONE);
        check("in_start", 32'(tx_start), 1);
        check("in_pkt", 32'(tx_packet), 32'(exp_pkt));
        check("in_noready", 32'(rx_data_ready), 0);
        check("in_noerr", 32'(rx_error), 0);
        tick(1);
        check("in_start_pulse", 32'(tx_start), 0);
        tx_finish(exp_pkt);
        check("in_start_total", 32'(n_start - base_start), 1);
    endtask

    task automatic out_txn(input int o0, input bit same);
        int         level, pushed, base_push, base_start, rem, exp_total;
        bit         dropped, done_now, exp_push;
        logic [2:0] exp_pkt;
        base_push  = n_push;
        base_start = n_start;
        pkt(P_OUT);
        byte_strobe(8'h00);
        byte_strobe(8'h29);
        pkt(P_DONE);
        tick(4);
        check("tok_no_push", 32'(n_push - base_push), 0);
        pkt(P_DATA);
        tick(2);
        level    = o0;
        pushed   = 0;
        dropped  = 1'b0;
        done_now = 1'b0;
        for (int k = 0; k < pay_n; k++) begin
            buffer_occupancy = 7'(level);
            exp_push = (k >= 2) && (level < DEPTH);
            if (k >= 2 && !exp_push) dropped = 1'b1;
            rx_packet_data       = pay[k];
            store_rx_packet_data = 1'b1;
            if (same && k == pay_n - 1) begin
                rx_packet = P_DONE;
                done_now  = 1'b1;
            end
            tick(1);
            store_rx_packet_data = 1'b0;
            check("push_strobe", 32'(rx_push), 32'(exp_push));
            if (exp_push) begin
                check("push_data", 32'(rx_push_data), 32'(pay[k-2]));
                level++;
                pushed++;
            end
            if (!done_now) tick(63);
        end
        if (!done_now) pkt(P_DONE);
        exp_pkt = dropped ? T_NAK : T_ACK;
        if (pay_n < 2) begin
            check("short_err", 32'(rx_error), 1);
            check("short_nostart", 32'(tx_start), 0);
            check("short_cnt", 32'(rx_byte_count), 0);
            tick(1);
            check("short_err_pulse", 32'(rx_error), 0);
            tick(3);
        end else begin
            check("resp_start", 32'(tx_start), 1);
            check("resp_pkt", 32'(tx_packet), 32'(exp_pkt));
            check("resp_ready", 32'(rx_data_ready), 32'(!dropped));
            check("resp_noerr", 32'(rx_error), 0);
            check("resp_cnt", 32'(rx_byte_count), 32'(pushed));
            tick(1);
            check("resp_start_pulse", 32'(tx_start), 0);
            check("resp_ready_pulse", 32'(rx_data_ready), 0);
            tx_finish(exp_pkt);
        end
        rem = DEPTH - o0;
        if (rem < 0) rem = 0;
        exp_total = (pay_n < 2) ? 0 : ((pay_n - 2 < rem) ? pay_n - 2 : rem);
        check("push_total", 32'(n_push - base_push), 32'(exp_total));
        check("start_total", 32'(n_start - base_start), (pay_n < 2) ? 0 : 1);
    endtask

    initial begin
        int  c;
        bit  found;
        int  base_push, base_start, base_err, sel, o0;

        n_rst                = 1'b0;
        rx_packet            = 3'b000;
        rx_packet_data       = 8'h00;
        store_rx_packet_data = 1'b0;
        buffer_occupancy     = 7'd0;
        tx_done              = 1'b0;
        tick(3);
        check_all_zero("reset");
        n_rst = 1'b1;
        tick(2);

        // Basic OUT: two payload bytes plus CRC16.
        pay[0] = 8'hAA; pay[1] = 8'hAF; pay[2] = 8'hFF; pay[3] = 8'hE8;
        pay_n = 4;
        out_txn(0, 1'b0);

        // IN with empty then non-empty buffer.
        in_txn(0);
        in_txn(5);

        // Buffer one short of full: exactly one payload byte fits.
        for (int i = 0; i < 6; i++) pay[i] = 8'(8'h30 + i);
        pay_n = 6;
        out_txn(63, 1'b0);

        // Data packet never arrives.
        base_start = n_start;
        pkt(P_OUT);
        pkt(P_DONE);
        found = 1'b0;
        c = 0;
        while (c < 2200 && !found) begin
            tick(1);
            c++;
            if (rx_error) found = 1'b1;
        end
        check("timeout_seen", 32'(found), 1);
        check("timeout_window", 32'(c >= 2040 && c <= 2060), 1);
        tick(1);
        check("timeout_err_pulse", 32'(rx_error), 0);
        check("timeout_nostart", 32'(n_start - base_start), 0);

        // ERROR after the second data byte.
        base_push  = n_push;
        base_start = n_start;
        pkt(P_OUT);
        pkt(P_DONE);
        tick(2);
        pkt(P_DATA);
        tick(2);
        buffer_occupancy = 7'd0;
        byte_strobe(8'h11);
        byte_strobe(8'h22);
        pkt(P_ERROR);
        check("abort_err", 32'(rx_error), 1);
        tick(1);
        check("abort_err_pulse", 32'(rx_error), 0);
        tick(10);
        check("abort_nopush", 32'(n_push - base_push), 0);
        check("abort_nostart", 32'(n_start - base_start), 0);
        for (int i = 0; i < 5; i++) pay[i] = 8'(8'hC0 + i);
        pay_n = 5;
        out_txn(0, 1'b1);

        // Reset in the middle of a data packet, stale DONE afterwards.
        pkt(P_OUT);
        pkt(P_DONE);
        tick(2);
        pkt(P_DATA);
        tick(2);
        buffer_occupancy = 7'd0;
        byte_strobe(8'h01);
        byte_strobe(8'h02);
        rx_packet_data       = 8'h03;
        store_rx_packet_data = 1'b1;
        tick(1);
        store_rx_packet_data = 1'b0;
        check("prereset_push", 32'(rx_push), 1);
        n_rst     = 1'b0;
        rx_packet = P_DONE;
        tick(1);
        check_all_zero("midreset");
        tick(2);
        n_rst      = 1'b1;
        base_start = n_start;
        base_err   = n_err;
        tick(10);
        check("stale_nostart", 32'(n_start - base_start), 0);
        check("stale_noerr", 32'(n_err - base_err), 0);
        in_txn(3);

        // Randomised mix of transactions.
        for (int it = 0; it < 18; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                in_txn(int'($urandom_range(0, 3)));
            end else begin
                pay_n = int'($urandom_range(0, 7));
                for (int i = 0; i < pay_n; i++) pay[i] = 8'($urandom);
                sel = int'($urandom_range(0, 3));
                if (sel == 0)      o0 = 0;
                else if (sel == 1) o0 = int'($urandom_range(60, 64));
                else               o0 = int'($urandom_range(0, 64));
                out_txn(o0, 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
